sar_adc: RTL and testbench

Successive-approximation ADC model, the inverse of the team's `dac`. It samples a real-valued analog input on `start` and resolves it MSB-first into a `bits`-wide code, one bit per clock. It then presents the code with a one-cycle `valid` pulse. It sits on the digital side of RNM mixed-signal benches and pairs with `dac` for round-trip formal checks, where `dac(sar_adc(x))` must lie within one LSB below `x`.

---
 rtl/sar_adc_pkg.sv | 19 +
 rtl/sar_adc_trial_dac.sv | 19 +
 rtl/sar_adc.sv | 103 ++++++++++
 tb/tb_sar_adc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared types, defaults and helpers for the successive-approximation ADC.
//   sar_state_t  : conversion FSM states.
//   BITS         : default output code width.
//   code_to_real : code * vref / 2^bits. The formal harness uses it as well.
package sar_adc_pkg;

    localparam int unsigned BITS = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } sar_state_t;

    function automatic real code_to_real(input longint unsigned code, input int unsigned bits,
                                         input real vref);
        return real'(code) * vref / (2.0 ** bits);
    endfunction

endpackage

// File: rtl/sar_adc_trial_dac.sv
// sar_trial_dac: combinational trial DAC used inside the SAR loop.
// A formal harness can swap this block for the real dac model.
//   code_i    [0:bits-1]  trial code; bit 0 is the MSB.
//   vtrial_o  real        trial voltage = code_i * vref / 2^bits.
module sar_trial_dac
    import sar_adc_pkg::*;
#(
    parameter int unsigned bits = BITS,
    parameter real         vref = 1.0
) (
    input  logic [0:bits-1] code_i,
    output real             vtrial_o
);

    always_comb begin
        vtrial_o = code_to_real(64'(code_i), bits, vref);
    end

endmodule

// File: rtl/sar_adc.sv
// sar_adc: successive-approximation ADC model.
// The analog input is sampled when start is accepted. The code is then resolved MSB first,
// one bit per clock.
//   clk    in   conversion clock, rising edge
//   rst    in   synchronous active-low reset
//   in     in   real analog input; sampled only on the accepting edge
//   start  in   conversion request; honoured only in IDLE
//   out    out  [0:bits-1] result code, out[0] = MSB; holds until the next completion
//   busy   out  high while a conversion is in flight
//   valid  out  one-cycle pulse on the edge that updates out
module sar_adc
    import sar_adc_pkg::*;
#(
    parameter int unsigned bits = BITS,
    parameter real         vref = 1.0
) (
    input  logic            clk,
    input  logic            rst,
    input  real             in,
    input  logic            start,
    output logic [0:bits-1] out,
    output logic            busy,
    output logic            valid
);

    localparam int unsigned    IdxW    = (bits > 1) ? $clog2(bits) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(bits - 1);

    sar_state_t      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [0:bits-1] code_q, code_d;
    logic [0:bits-1] out_q, out_d;
    logic            valid_q, valid_d;
    real             vin_q, vin_d;
    real             trial_v;

    sar_trial_dac #(
        .bits (bits),
        .vref (vref)
    ) u_trial_dac (
        .code_i   (code_q),
        .vtrial_o (trial_v)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        code_d  = code_q;
        out_d   = out_q;
        vin_d   = vin_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    vin_d     = in;
                    code_d    = '0;
                    code_d[0] = 1'b1;
                    idx_d     = '0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                // The bit under trial stays set only if the sample reaches the trial level.
                // Out-of-range inputs saturate naturally to all zeros or all ones.
                if (vin_q < trial_v) begin
                    code_d[idx_q] = 1'b0;
                end
                if (idx_q == LastIdx) begin
                    out_d   = code_d;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    code_d[idx_q + 1'b1] = 1'b1;
                    idx_d                = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            code_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            vin_q   <= 0.0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            vin_q   <= vin_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = (state_q == CONVERT);

endmodule

// File: tb/tb_sar_adc.sv
// tb_sar_adc: self-checking bench for sar_adc using directed and random conversions.
// The bench computes each expected code as floor(v / LSB), clamped to the code range.
module tb_sar_adc;

    localparam int unsigned BITS = 8;
    localparam real         VREF = 1.0;

    logic            clk;
    logic            rst;
    real             ain;
    logic            start;
    logic [0:BITS-1] out;
    logic            busy;
    logic            valid;

    int n_checks;
    int n_pass;
    int prev_out;

    sar_adc #(
        .bits (BITS),
        .vref (VREF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (ain),
        .start (start),
        .out   (out),
        .busy  (busy),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_code(input real v);
        real x;
        x = $floor(v * (2.0 ** BITS) / VREF);
        if (x < 0.0) return 0;
        if (x > (2.0 ** BITS) - 1.0) return (1 << BITS) - 1;
        return int'(x);
    endfunction

    // The start edge is k. The task checks each cycle through k+BITS and then one more cycle.
    // chg_at: after edge k+chg_at, in changes to v2. pulse_at: start is pulsed after that edge.
    task automatic convert(input real v, input string name, input int chg_at, input real v2,
                           input int pulse_at);
        int exp_code;
        exp_code = model_code(v);
        ain   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(BITS); i++) begin
            n_checks++;
            if (busy !== 1'b1 || valid !== 1'b0 || int'(out) !== prev_out)
                $display("FAIL %s cyc%0d: busy=%b valid=%b out=%0d, want busy=1 valid=0 out=%0d",
                         name, i, busy, valid, out, prev_out);
            else n_pass++;
            if (i == chg_at) ain = v2;
            start = (i == pulse_at);
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b1 || int'(out) !== exp_code)
            $display("FAIL %s done: busy=%b valid=%b out=%0d, want busy=0 valid=1 out=%0d",
                     name, busy, valid, out, exp_code);
        else n_pass++;
        prev_out = exp_code;
        tick();
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || int'(out) !== prev_out)
            $display("FAIL %s after: busy=%b valid=%b out=%0d, want busy=0 valid=0 out=%0d",
                     name, busy, valid, out, prev_out);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        ain   = 0.5;
        tick();
        tick();
        n_checks++;
        if (out !== '0 || busy !== 1'b0 || valid !== 1'b0)
            $display("FAIL reset: out=%0d busy=%b valid=%b, want 0/0/0", out, busy, valid);
        else n_pass++;
        start = 1'b0;
        rst   = 1'b1;
        prev_out = 0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0)
            $display("FAIL reset_idle: busy=%b valid=%b, want 0/0", busy, valid);
        else n_pass++;
    endtask

    task automatic test_directed();
        real vals[8];
        vals = '{0.5, 0.3, -0.2, 1.2, 255.0 / 256.0, 1.0 / 256.0, 0.0, 0.75};
        foreach (vals[i]) convert(vals[i], $sformatf("directed%0d", i), -1, 0.0, -1);
    endtask

    task automatic test_hold_input();
        convert(0.3, "hold_input", 3, 0.9, -1);
    endtask

    task automatic test_ignore_start();
        convert(0.6, "ignore_start", -1, 0.0, 4);
    endtask

    task automatic test_reset_mid();
        ain   = 0.6;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_checks++;
        if (out !== '0 || busy !== 1'b0 || valid !== 1'b0)
            $display("FAIL reset_mid: out=%0d busy=%b valid=%b, want 0/0/0", out, busy, valid);
        else n_pass++;
        prev_out = 0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0)
            $display("FAIL reset_mid_after: busy=%b valid=%b, want 0/0", busy, valid);
        else n_pass++;
        convert(0.3, "reset_mid_restart", -1, 0.0, -1);
    endtask

    task automatic test_reset_on_complete();
        ain   = 0.4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (BITS - 1) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_checks++;
        if (valid !== 1'b0 || out !== '0 || busy !== 1'b0)
            $display("FAIL reset_complete: valid=%b out=%0d busy=%b, want 0/0/0",
                     valid, out, busy);
        else n_pass++;
        prev_out = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        int period;
        int n_valid;
        period  = BITS + 1;
        n_valid = 0;
        ain     = 0.75;
        start   = 1'b1;
        for (int c = 1; c <= 3 * period; c++) begin
            tick();
            if (c == 3 * period) start = 1'b0;
            n_checks++;
            if (valid !== ((c % period) == 0))
                $display("FAIL back_to_back_valid c%0d: valid=%b, want %b",
                         c, valid, (c % period) == 0);
            else n_pass++;
            if (valid === 1'b1) begin
                n_valid++;
                n_checks++;
                if (int'(out) !== model_code(0.75))
                    $display("FAIL back_to_back_out c%0d: out=%0d, want %0d",
                             c, out, model_code(0.75));
                else n_pass++;
            end
        end
        n_checks++;
        if (n_valid != 3)
            $display("FAIL back_to_back_count: %0d valid pulses, want 3", n_valid);
        else n_pass++;
        prev_out = model_code(0.75);
        tick();
    endtask

    task automatic test_random();
        real v;
        for (int i = 0; i < 20; i++) begin
            v = real'($urandom_range(1000000, 0)) / 1000000.0 * 1.4 - 0.2;
            convert(v, $sformatf("random%0d", i), -1, 0.0, -1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        prev_out = 0;
        rst      = 1'b0;
        start    = 1'b0;
        ain      = 0.0;
        test_reset();
        test_directed();
        test_hold_input();
        test_ignore_start();
        test_reset_mid();
        test_reset_on_complete();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
